// File: rtl/ysyx_25050148_lsu_if.sv
// Bundle of LSU request, data-memory and response signals.
// The slave modport is the LSU side; the master modport is the environment
// side, which drives requests, supplies memory data and accepts responses.
interface ysyx_25050148_lsu_if;
  // request from execute stage
  logic        in_valid;
  logic        in_ready;
  logic        in_wen;
  logic [1:0]  in_len;
  logic        in_signed;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [4:0]  in_rd;

  // data-memory port
  logic        mem_read_en;
  logic        mem_write_en;
  logic        mem_read_flag;
  logic [1:0]  mem_read_len;
  logic [31:0] mem_raddr;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_wdata_len;
  logic [31:0] mem_read_data;

  // response to write-back
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [4:0]  out_rd;
  logic        out_err;

  modport slave (
    input  in_valid, in_wen, in_len, in_signed, in_addr, in_wdata, in_rd,
    output in_ready,
    output mem_read_en, mem_write_en, mem_read_flag, mem_read_len,
    output mem_raddr, mem_waddr, mem_wdata, mem_wdata_len,
    input  mem_read_data,
    output out_valid, out_rdata, out_rd, out_err,
    input  out_ready
  );

  modport master (
    output in_valid, in_wen, in_len, in_signed, in_addr, in_wdata, in_rd,
    input  in_ready,
    input  mem_read_en, mem_write_en, mem_read_flag, mem_read_len,
    input  mem_raddr, mem_waddr, mem_wdata, mem_wdata_len,
    output mem_read_data,
    input  out_valid, out_rdata, out_rd, out_err,
    output out_ready
  );
endinterface

// File: rtl/ysyx_25050148_lsu.sv
// Load/store unit: accepts one request at a time, issues a single-cycle
// memory access, waits LATENCY-1 further cycles, then holds a response
// until write-back takes it. Misaligned requests skip memory entirely and
// respond with an error flag.
module ysyx_25050148_lsu #(
  parameter int unsigned LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ysyx_25050148_lsu_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  // WAIT lasts LATENCY-1 cycles; the counter is loaded on leaving ACCESS
  localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;

  logic        req_wen;
  logic [1:0]  req_len;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        ready;
  logic        accept;
  logic        misaligned;

  // half needs addr[0]=0, word needs addr[1:0]=0, len=3 is never legal
  function automatic logic is_misaligned(input logic [1:0] len, input logic [1:0] addr_lo);
    logic m;
    case (len)
      2'd0:    m = 1'b0;
      2'd1:    m = addr_lo[0];
      2'd2:    m = (addr_lo != 2'd0);
      default: m = 1'b1;
    endcase
    return m;
  endfunction

  // byte count for the store strobe
  function automatic logic [31:0] len_to_bytes(input logic [1:0] len);
    logic [31:0] n;
    case (len)
      2'd0:    n = 32'd1;
      2'd1:    n = 32'd2;
      2'd2:    n = 32'd4;
      default: n = 32'd0;
    endcase
    return n;
  endfunction

  // in_ready is forced low during reset so no request is taken in that cycle
  assign ready      = (state == S_IDLE) && rst_n;
  assign accept     = bus.in_valid && ready;
  assign misaligned = is_misaligned(bus.in_len, bus.in_addr[1:0]);

  // next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (misaligned) begin
            state_next = S_RESP;
          end else begin
            state_next = S_ACCESS;
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (LATENCY > 1) begin
          state_next = S_WAIT;
        end else begin
          state_next = S_RESP;
        end
      end
      S_WAIT: begin
        if (cnt <= 4'd1) begin
          state_next = S_RESP;
        end else begin
          state_next = S_WAIT;
        end
      end
      S_RESP: begin
        if (bus.out_ready) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_RESP;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // request latch, wait counter and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_wen    <= 1'b0;
      req_len    <= 2'd0;
      req_signed <= 1'b0;
      req_addr   <= 32'd0;
      req_wdata  <= 32'd0;
      req_rd     <= 5'd0;
      cnt        <= 4'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      // out_valid simply tracks residence in RESP, registered
      resp_valid <= (state_next == S_RESP);
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_wen    <= bus.in_wen;
            req_len    <= bus.in_len;
            req_signed <= bus.in_signed;
            req_addr   <= bus.in_addr;
            req_wdata  <= bus.in_wdata;
            req_rd     <= bus.in_rd;
            resp_rdata <= 32'd0;
            resp_err   <= misaligned;
          end
        end
        S_ACCESS: begin
          // memory returns already-extended load data during ACCESS
          resp_rdata <= req_wen ? 32'd0 : bus.mem_read_data;
          cnt        <= WAIT_LOAD;
        end
        S_WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          resp_err <= resp_err;
        end
        default: begin
          cnt <= 4'd0;
        end
      endcase
    end
  end

  assign bus.in_ready      = ready;

  // enables are gated by rst_n so an in-flight store is dropped on reset
  assign bus.mem_read_en   = (state == S_ACCESS) && !req_wen && rst_n;
  assign bus.mem_write_en  = (state == S_ACCESS) &&  req_wen && rst_n;
  assign bus.mem_read_flag = req_signed;
  assign bus.mem_read_len  = req_len;
  assign bus.mem_raddr     = req_addr;
  assign bus.mem_waddr     = req_addr;
  assign bus.mem_wdata     = req_wdata;
  assign bus.mem_wdata_len = len_to_bytes(req_len);

  assign bus.out_valid     = resp_valid;
  assign bus.out_rdata     = resp_rdata;
  assign bus.out_rd        = req_rd;
  assign bus.out_err       = resp_err;

endmodule

// File: tb/tb_ysyx_25050148_lsu.sv
// Directed bench for the LSU: one instance with LATENCY=1 for the main
// functions and one with LATENCY=3 for wait-state and backpressure timing.
module tb_ysyx_25050148_lsu;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  ysyx_25050148_lsu_if if1 ();
  ysyx_25050148_lsu_if if3 ();

  ysyx_25050148_lsu #(.LATENCY(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  ysyx_25050148_lsu #(.LATENCY(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if1.in_valid = 1'b0; if1.in_wen = 1'b0; if1.in_len = 2'd0; if1.in_signed = 1'b0;
    if1.in_addr = 32'd0; if1.in_wdata = 32'd0; if1.in_rd = 5'd0;
    if1.mem_read_data = 32'd0; if1.out_ready = 1'b1;
    if3.in_valid = 1'b0; if3.in_wen = 1'b0; if3.in_len = 2'd0; if3.in_signed = 1'b0;
    if3.in_addr = 32'd0; if3.in_wdata = 32'd0; if3.in_rd = 5'd0;
    if3.mem_read_data = 32'd0; if3.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if1.in_valid = 1'b1;
    #1;
    total++; if (if1.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready_low got=%0b want=0", if1.in_ready); end
    tick(); tick();
    total++; if (if1.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b want=0", if1.out_valid); end
    total++; if (if1.out_rdata !== 32'd0 || if1.out_rd !== 5'd0 || if1.out_err !== 1'b0)
      begin bad++; $display("FAIL rst_out_fields got=%h/%0d/%0b want=0/0/0", if1.out_rdata, if1.out_rd, if1.out_err); end
    total++; if (if1.mem_read_en !== 1'b0 || if1.mem_write_en !== 1'b0)
      begin bad++; $display("FAIL rst_mem_en got=%0b%0b want=00", if1.mem_read_en, if1.mem_write_en); end
    if1.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    total++; if (if1.in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%0b want=1", if1.in_ready); end
    total++; if (if3.in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready3 got=%0b want=1", if3.in_ready); end
  endtask

  task automatic test_word_load();
    if1.out_ready = 1'b0;
    if1.in_valid = 1'b1; if1.in_wen = 1'b0; if1.in_len = 2'd2; if1.in_signed = 1'b0;
    if1.in_addr = 32'h8000_0004; if1.in_rd = 5'd5; if1.mem_read_data = 32'hDEAD_BEEF;
    tick();  // accept edge
    if1.in_valid = 1'b0;
    total++; if (if1.mem_read_en !== 1'b1 || if1.mem_write_en !== 1'b0)
      begin bad++; $display("FAIL load_access_en got=%0b%0b want=10", if1.mem_read_en, if1.mem_write_en); end
    total++; if (if1.mem_read_len !== 2'd2 || if1.mem_raddr !== 32'h8000_0004)
      begin bad++; $display("FAIL load_access_ctl got=%0d/%h want=2/80000004", if1.mem_read_len, if1.mem_raddr); end
    total++; if (if1.out_valid !== 1'b0 || if1.in_ready !== 1'b0)
      begin bad++; $display("FAIL load_access_hs got=%0b%0b want=00", if1.out_valid, if1.in_ready); end
    tick();
    if1.mem_read_data = 32'h1111_2222;  // captured value must not follow
    #1;
    total++; if (if1.out_valid !== 1'b1) begin bad++; $display("FAIL load_valid got=%0b want=1", if1.out_valid); end
    total++; if (if1.out_rdata !== 32'hDEAD_BEEF || if1.out_err !== 1'b0 || if1.out_rd !== 5'd5)
      begin bad++; $display("FAIL load_resp got=%h/%0b/%0d want=deadbeef/0/5", if1.out_rdata, if1.out_err, if1.out_rd); end
    total++; if (if1.mem_read_en !== 1'b0) begin bad++; $display("FAIL load_en_one_cycle got=%0b want=0", if1.mem_read_en); end
    if1.out_ready = 1'b1;
    #1;
    total++; if (if1.in_ready !== 1'b0) begin bad++; $display("FAIL load_bubble got=%0b want=0", if1.in_ready); end
    tick();
    total++; if (if1.out_valid !== 1'b0 || if1.in_ready !== 1'b1)
      begin bad++; $display("FAIL load_done got=%0b%0b want=01", if1.out_valid, if1.in_ready); end
  endtask

  task automatic test_byte_store();
    if1.in_valid = 1'b1; if1.in_wen = 1'b1; if1.in_len = 2'd0; if1.in_signed = 1'b0;
    if1.in_addr = 32'h8000_0003; if1.in_wdata = 32'h0000_00A5; if1.in_rd = 5'd7;
    if1.mem_read_data = 32'h5555_AAAA;
    tick();
    if1.in_valid = 1'b0;
    total++; if (if1.mem_write_en !== 1'b1 || if1.mem_read_en !== 1'b0)
      begin bad++; $display("FAIL store_en got=%0b%0b want=10", if1.mem_write_en, if1.mem_read_en); end
    total++; if (if1.mem_waddr !== 32'h8000_0003 || if1.mem_wdata !== 32'h0000_00A5 || if1.mem_wdata_len !== 32'd1)
      begin bad++; $display("FAIL store_bus got=%h/%h/%0d want=80000003/000000a5/1", if1.mem_waddr, if1.mem_wdata, if1.mem_wdata_len); end
    tick();
    total++; if (if1.out_valid !== 1'b1 || if1.out_rdata !== 32'd0 || if1.out_err !== 1'b0)
      begin bad++; $display("FAIL store_resp got=%0b/%h/%0b want=1/0/0", if1.out_valid, if1.out_rdata, if1.out_err); end
    total++; if (if1.mem_write_en !== 1'b0) begin bad++; $display("FAIL store_en_one_cycle got=%0b want=0", if1.mem_write_en); end
    tick();
    total++; if (if1.out_valid !== 1'b0) begin bad++; $display("FAIL store_done got=%0b want=0", if1.out_valid); end
  endtask

  task automatic test_half_signed();
    if1.in_valid = 1'b1; if1.in_wen = 1'b0; if1.in_len = 2'd1; if1.in_signed = 1'b1;
    if1.in_addr = 32'h8000_0002; if1.in_rd = 5'd3; if1.mem_read_data = 32'hFFFF_8001;
    tick();
    if1.in_valid = 1'b0;
    total++; if (if1.mem_read_en !== 1'b1 || if1.mem_read_flag !== 1'b1 || if1.mem_read_len !== 2'd1)
      begin bad++; $display("FAIL half_ctl got=%0b/%0b/%0d want=1/1/1", if1.mem_read_en, if1.mem_read_flag, if1.mem_read_len); end
    tick();
    total++; if (if1.out_rdata !== 32'hFFFF_8001 || if1.out_err !== 1'b0)
      begin bad++; $display("FAIL half_resp got=%h/%0b want=ffff8001/0", if1.out_rdata, if1.out_err); end
    tick();
  endtask

  task automatic test_misaligned();
    logic [1:0]  lens [3];
    logic [31:0] addrs [3];
    lens[0] = 2'd1; addrs[0] = 32'h8000_0001;
    lens[1] = 2'd2; addrs[1] = 32'h8000_0002;
    lens[2] = 2'd3; addrs[2] = 32'h8000_0000;
    if1.mem_read_data = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      if1.in_valid = 1'b1; if1.in_wen = 1'b0; if1.in_len = lens[i]; if1.in_signed = 1'b1;
      if1.in_addr = addrs[i]; if1.in_rd = 5'(10 + i);
      tick();
      if1.in_valid = 1'b0;
      total++; if (if1.out_valid !== 1'b1 || if1.out_err !== 1'b1 || if1.out_rdata !== 32'd0)
        begin bad++; $display("FAIL misal_resp[%0d] got=%0b/%0b/%h want=1/1/0", i, if1.out_valid, if1.out_err, if1.out_rdata); end
      total++; if (if1.mem_read_en !== 1'b0 || if1.mem_write_en !== 1'b0)
        begin bad++; $display("FAIL misal_no_mem[%0d] got=%0b%0b want=00", i, if1.mem_read_en, if1.mem_write_en); end
      tick();
      total++; if (if1.out_valid !== 1'b0 || if1.in_ready !== 1'b1)
        begin bad++; $display("FAIL misal_done[%0d] got=%0b%0b want=01", i, if1.out_valid, if1.in_ready); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_ready;
    logic [3:0] exp_valid;
    exp_ready = 4'b0100;  // bit i: value after edge i+1, edges E0..E3
    exp_valid = 4'b0010;
    if1.in_valid = 1'b1; if1.in_wen = 1'b0; if1.in_len = 2'd2; if1.in_signed = 1'b0;
    if1.in_addr = 32'h8000_0010; if1.in_rd = 5'd1; if1.mem_read_data = 32'h0000_0042;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (if1.in_ready !== exp_ready[i] || if1.out_valid !== exp_valid[i])
        begin bad++; $display("FAIL b2b[%0d] got=%0b%0b want=%0b%0b", i, if1.in_ready, if1.out_valid, exp_ready[i], exp_valid[i]); end
    end
    total++; if (if1.mem_read_en !== 1'b1) begin bad++; $display("FAIL b2b_second_access got=%0b want=1", if1.mem_read_en); end
    if1.in_valid = 1'b0;
    tick(); tick();
  endtask

  task automatic test_backpressure();
    logic [3:0] exp_valid;
    exp_valid = 4'b1000;  // out_valid after E0,E1,E2,E3 for LATENCY=3
    if3.out_ready = 1'b0;
    if3.in_valid = 1'b1; if3.in_wen = 1'b0; if3.in_len = 2'd2; if3.in_signed = 1'b0;
    if3.in_addr = 32'h8000_0008; if3.in_rd = 5'd9; if3.mem_read_data = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      tick();
      if3.in_valid = 1'b0;
      total++; if (if3.out_valid !== exp_valid[i])
        begin bad++; $display("FAIL bp_latency[%0d] got=%0b want=%0b", i, if3.out_valid, exp_valid[i]); end
      total++; if (if3.mem_read_en !== (i == 0))
        begin bad++; $display("FAIL bp_read_en[%0d] got=%0b want=%0b", i, if3.mem_read_en, (i == 0)); end
    end
    if3.mem_read_data = 32'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (if3.out_valid !== 1'b1 || if3.in_ready !== 1'b0)
        begin bad++; $display("FAIL bp_hold[%0d] got=%0b%0b want=10", i, if3.out_valid, if3.in_ready); end
      total++; if (if3.out_rdata !== 32'h1234_5678 || if3.out_rd !== 5'd9 || if3.out_err !== 1'b0)
        begin bad++; $display("FAIL bp_stable[%0d] got=%h/%0d/%0b want=12345678/9/0", i, if3.out_rdata, if3.out_rd, if3.out_err); end
    end
    if3.out_ready = 1'b1;
    tick();
    total++; if (if3.out_valid !== 1'b0 || if3.in_ready !== 1'b1)
      begin bad++; $display("FAIL bp_release got=%0b%0b want=01", if3.out_valid, if3.in_ready); end
    if3.out_ready = 1'b0;
  endtask

  task automatic test_reset_in_access();
    if1.in_valid = 1'b1; if1.in_wen = 1'b1; if1.in_len = 2'd2; if1.in_signed = 1'b0;
    if1.in_addr = 32'h8000_0020; if1.in_wdata = 32'h7777_8888; if1.in_rd = 5'd4;
    tick();
    if1.in_valid = 1'b0;
    total++; if (if1.mem_write_en !== 1'b1) begin bad++; $display("FAIL rsta_pre got=%0b want=1", if1.mem_write_en); end
    rst_n = 1'b0;
    #1;
    total++; if (if1.mem_write_en !== 1'b0 || if1.in_ready !== 1'b0)
      begin bad++; $display("FAIL rsta_gate got=%0b%0b want=00", if1.mem_write_en, if1.in_ready); end
    tick();
    rst_n = 1'b1;
    #1;
    total++; if (if1.in_ready !== 1'b1 || if1.out_valid !== 1'b0 || if1.mem_write_en !== 1'b0)
      begin bad++; $display("FAIL rsta_idle got=%0b%0b%0b want=100", if1.in_ready, if1.out_valid, if1.mem_write_en); end
    total++; if (if1.mem_waddr !== 32'd0 || if1.out_rd !== 5'd0)
      begin bad++; $display("FAIL rsta_cleared got=%h/%0d want=0/0", if1.mem_waddr, if1.out_rd); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_word_load();
    test_byte_store();
    test_half_signed();
    test_misaligned();
    test_back_to_back();
    test_backpressure();
    test_reset_in_access();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
